uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high (clock port bd_clk, reset port rst).
REQ-002 Parameter DATA_BITS, default 8: payload bits per frame.
REQ-003 Parameter DEPTH, default 4: transmit FIFO entries, power of two and at least 2.
REQ-004 bd_clk  input  1  baud clock; one serial bit per rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 wr_en  input  1  write request; sampled on bd_clk rising edge.
REQ-007 wr_data  input  DATA_BITS  byte to enqueue when wr_en is high.
REQ-008 tx_full  output  1  FIFO holds DEPTH entries.
REQ-009 tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-010 fifo_count  output  clog2(DEPTH)+1  number of occupied FIFO entries.
REQ-011 tx_data  output  1  registered serial line to the receiver; idle level is high.

Function
REQ-012 Frame format SHALL be 1 start bit (0), then DATA_BITS data bits LSB first, then 1 stop bit (1); each bit lasts exactly one bd_clk cycle.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP; all states except DATA last 1 cycle, and DATA lasts DATA_BITS cycles under a bit counter.
REQ-014 Transitions SHALL be: IDLE->START when FIFO non-empty (head popped into shift register the same edge); START->DATA; DATA->STOP when bit counter = DATA_BITS-1; STOP->IDLE unconditionally.
REQ-015 Every frame SHALL therefore be followed by at least one IDLE cycle with tx_data=1, giving a back-to-back period of DATA_BITS+3 cycles.
REQ-016 Latency SHALL be: write accepted at edge N into an empty FIFO while IDLE -> tx_data=0 after edge N+1.
REQ-017 A write with wr_en=1 and tx_full=0 SHALL enqueue wr_data and increment fifo_count.
REQ-018 A write while tx_full=1 SHALL be dropped, even if a pop occurs on the same edge; FIFO contents SHALL be unchanged.
REQ-019 A simultaneous accepted write and pop SHALL leave fifo_count unchanged.
REQ-020 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-021 tx_full SHALL equal (fifo_count==DEPTH), combinationally derived from the count.
REQ-022 tx_busy SHALL equal (state!=IDLE) or (fifo_count!=0).
REQ-023 wr_en during a frame SHALL not disturb the frame in flight.

Reset
REQ-024 On rst high at a bd_clk edge: state=IDLE, tx_data=1, fifo_count=0, pointers=0, bit counter=0, tx_full=0, tx_busy=0.
REQ-025 Reset mid-frame SHALL abort the frame and discard all queued bytes; tx_data SHALL be 1 after that edge.
REQ-026 A write in the same cycle as rst SHALL be ignored.

Structure
REQ-027 Shared package uart_pkg SHALL hold DATA_BITS default, the FSM state enum, and START_BIT=0/STOP_BIT=1 constants, shared with the receiver.
REQ-028 The FIFO SHALL be one sub-module, uart_tx_fifo (DEPTH and width parameterised, exposing push/pop/count); the FSM and shift register SHALL live in uart_tx.

Verification
REQ-029 Write 0xA5 in IDLE -> after the next edge, tx_data over 10 cycles reads 0,1,0,1,0,0,1,0,1,1, then stays 1; tx_busy low after STOP->IDLE.
REQ-030 Write 0x3C,0x81,0xFF,0x00 on consecutive cycles -> tx_full asserts after the 4th write, deasserts on the first pop; four frames are sent in order, each 11 cycles apart.
REQ-031 With the FIFO full, write 0x55 in the pop cycle -> 0x55 is dropped; fifo_count goes 4->3; exactly 4 frames are sent.
REQ-032 Assert rst at the 5th data bit of 0xA5 with 2 bytes queued -> tx_data=1, fifo_count=0, tx_busy=0 next cycle; no further frames are sent.
REQ-033 Loopback tx_data into the receiver with forward_rx_data=1; send 0x00, 0xFF, 0x5A -> the receiver rx_data matches each byte after its stop bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: default payload
// width, line-level constants and the frame FSM state encoding.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// Host-side write port and status of the UART transmitter, plus its serial line.
interface uart_tx_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
);

  logic                     wr_en;
  logic [DATA_BITS-1:0]     wr_data;
  logic                     tx_full;
  logic                     tx_busy;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     tx_data;

  modport master (
    output wr_en, wr_data,
    input  tx_full, tx_busy, fifo_count, tx_data
  );

  modport slave (
    input  wr_en, wr_data,
    output tx_full, tx_busy, fifo_count, tx_data
  );

endinterface : uart_tx_if

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO; a push while full is dropped even if a pop
// frees a slot on the same edge.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only read after it was written, so clearing it would add cost for nothing.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_ptr_q] <= push_data;
  end

endmodule : uart_tx_fifo

// File: rtl/uart_tx.sv
// UART transmitter: queued bytes are sent as start, LSB-first data, stop,
// one bit per baud clock, with a registered serial output.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int DEPTH     = 4
) (
  input  logic     bd_clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam int BIT_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

  uart_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                     tx_data_q, tx_data_d;

  logic                     fifo_pop;
  logic [DATA_BITS-1:0]     fifo_head;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     fifo_full;
  logic                     fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (bd_clk),
    .rst       (rst),
    .push      (bus.wr_en),
    .push_data (bus.wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // tx_data_d is the line level for the state being entered, keeping the output registered.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_data_d = tx_data_q;
    fifo_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_data_d = STOP_BIT;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_head;
          state_d   = ST_START;
          tx_data_d = START_BIT;
        end
      end
      ST_START: begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
        tx_data_d = shift_q[0];
        shift_d   = shift_q >> 1;
      end
      ST_DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = ST_STOP;
          bit_cnt_d = '0;
          tx_data_d = STOP_BIT;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          tx_data_d = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      ST_STOP: begin
        state_d   = ST_IDLE;
        tx_data_d = STOP_BIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge bd_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_data_q <= STOP_BIT;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_full    = fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.tx_busy    = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx; a line decoder rebuilds bytes from tx_data.
module tb_uart_tx;

  logic bd_clk = 1'b0;
  logic rst;

  uart_tx_if #(.DATA_BITS(8), .DEPTH(4)) bus ();

  uart_tx #(.DATA_BITS(8), .DEPTH(4)) dut (
    .bd_clk (bd_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 bd_clk = ~bd_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rx_frame_err = 0;
  logic [7:0] rx_q [$];
  int         rx_start_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge bd_clk);
    #1;
  endtask

  // Receiver model: hunts for a start bit, collects 8 bits LSB first, checks stop.
  initial begin : rx_model
    int pos;
    int st;
    logic [7:0] sh;
    logic r;
    pos = -1;
    st  = 0;
    sh  = '0;
    forever begin
      @(posedge bd_clk);
      r = rst;
      cyc++;
      #2;
      if (r) pos = -1;
      else if (pos < 0) begin
        if (bus.tx_data === 1'b0) begin
          pos = 0;
          st  = cyc;
        end
      end else if (pos < 8) begin
        sh[pos] = bus.tx_data;
        pos++;
      end else begin
        if (bus.tx_data === 1'b1) begin
          rx_q.push_back(sh);
          rx_start_q.push_back(st);
        end else rx_frame_err++;
        pos = -1;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [9:0] a5_line;
    logic [7:0] exp_bytes [5];
    logic [7:0] loop_bytes [3];
    logic [7:0] got;
    int         prev_st;

    // Reset, with a write held high that must be ignored
    rst = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    tick(2);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd1);
    chk("rst_count",   32'(bus.fifo_count), 32'd0);
    chk("rst_full",    32'(bus.tx_full), 32'd0);
    chk("rst_busy",    32'(bus.tx_busy), 32'd0);
    rst = 1'b0;
    bus.wr_en = 1'b0;
    tick(1);
    chk("rst_write_ignored", 32'(bus.fifo_count), 32'd0);
    chk("post_rst_busy",     32'(bus.tx_busy), 32'd0);

    // Single frame 0xA5
    rx_q.delete(); rx_start_q.delete();
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick(1);
    bus.wr_en = 1'b0;
    chk("a5_count_after_write", 32'(bus.fifo_count), 32'd1);
    chk("a5_busy_after_write",  32'(bus.tx_busy), 32'd1);
    chk("a5_line_still_idle",   32'(bus.tx_data), 32'd1);
    tick(1);
    a5_line = 10'b1101001010;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("a5_bit%0d", i), 32'(bus.tx_data), 32'(a5_line[i]));
      if (i == 0) chk("a5_count_popped", 32'(bus.fifo_count), 32'd0);
      if (i == 9) chk("a5_busy_in_stop", 32'(bus.tx_busy), 32'd1);
      tick(1);
    end
    chk("a5_idle_line", 32'(bus.tx_data), 32'd1);
    chk("a5_idle_busy", 32'(bus.tx_busy), 32'd0);
    chk("a5_rx_count",  32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) chk("a5_rx_byte", 32'(rx_q.pop_front()), 32'hA5);

    // Fill while a frame is in flight, drop writes while full
    tick(2);
    rx_q.delete(); rx_start_q.delete();
    bus.wr_en = 1'b1; bus.wr_data = 8'h12;
    tick(1);
    chk("fill_count0", 32'(bus.fifo_count), 32'd1);
    bus.wr_data = 8'h3C;
    tick(1);
    chk("fill_count1_push_pop", 32'(bus.fifo_count), 32'd1);
    chk("fill_start_bit",       32'(bus.tx_data), 32'd0);
    bus.wr_data = 8'h81;
    tick(1);
    chk("fill_count2", 32'(bus.fifo_count), 32'd2);
    bus.wr_data = 8'hFF;
    tick(1);
    chk("fill_count3", 32'(bus.fifo_count), 32'd3);
    chk("fill_not_full3", 32'(bus.tx_full), 32'd0);
    bus.wr_data = 8'h00;
    tick(1);
    chk("fill_count4", 32'(bus.fifo_count), 32'd4);
    chk("fill_full4",  32'(bus.tx_full), 32'd1);
    bus.wr_data = 8'hEE;
    tick(1);
    bus.wr_en = 1'b0;
    chk("full_drop_count", 32'(bus.fifo_count), 32'd4);
    tick(6);
    chk("full_before_pop", 32'(bus.tx_full), 32'd1);
    chk("full_idle_line",  32'(bus.tx_data), 32'd1);
    chk("full_busy",       32'(bus.tx_busy), 32'd1);
    bus.wr_en = 1'b1; bus.wr_data = 8'h55;
    tick(1);
    bus.wr_en = 1'b0;
    chk("pop_drop_count", 32'(bus.fifo_count), 32'd3);
    chk("pop_full_clear", 32'(bus.tx_full), 32'd0);
    chk("pop_start_bit",  32'(bus.tx_data), 32'd0);
    tick(50);
    chk("fill_done_busy",  32'(bus.tx_busy), 32'd0);
    chk("fill_done_count", 32'(bus.fifo_count), 32'd0);
    chk("fill_rx_count",   32'(rx_q.size()), 32'd5);
    exp_bytes = '{8'h12, 8'h3C, 8'h81, 8'hFF, 8'h00};
    prev_st = 0;
    for (int i = 0; i < 5; i++) begin
      if (rx_q.size() > 0) begin
        got = rx_q.pop_front();
        chk($sformatf("fill_rx_byte%0d", i), 32'(got), 32'(exp_bytes[i]));
        if (i > 0) chk($sformatf("fill_gap%0d", i), 32'(rx_start_q[0] - prev_st), 32'd11);
        prev_st = rx_start_q.pop_front();
      end
    end

    // Reset mid-frame with two bytes queued
    rx_q.delete(); rx_start_q.delete();
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
    tick(1);
    bus.wr_data = 8'h11;
    tick(1);
    bus.wr_data = 8'h22;
    tick(1);
    bus.wr_en = 1'b0;
    chk("abort_queued", 32'(bus.fifo_count), 32'd2);
    tick(3);
    chk("abort_bit3", 32'(bus.tx_data), 32'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_tx_data", 32'(bus.tx_data), 32'd1);
    chk("abort_count",   32'(bus.fifo_count), 32'd0);
    chk("abort_busy",    32'(bus.tx_busy), 32'd0);
    tick(30);
    chk("abort_no_frames", 32'(rx_q.size()), 32'd0);
    chk("abort_line_idle", 32'(bus.tx_data), 32'd1);

    // Loopback through the receiver model
    loop_bytes = '{8'h00, 8'hFF, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      rx_q.delete(); rx_start_q.delete();
      bus.wr_en = 1'b1; bus.wr_data = loop_bytes[i];
      tick(1);
      bus.wr_en = 1'b0;
      tick(11);
      chk($sformatf("loop_rx_count%0d", i), 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) chk($sformatf("loop_rx_byte%0d", i), 32'(rx_q.pop_front()), 32'(loop_bytes[i]));
    end
    chk("framing_errors", 32'(rx_frame_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx
